// File: rtl/nasser_hadi_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM states,
// uio_in / uo_out field positions and shift-register helpers.
package nasser_hadi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      GAP   = 2'b10,
      DONE  = 2'b11
   } state_t;

   // uio_in fields
   localparam int unsigned LEN_LSB   = 0;
   localparam int unsigned LEN_MSB   = 2;
   localparam int unsigned START_BIT = 3;
   localparam int unsigned ORDER_BIT = 4;
   localparam int unsigned REP_LSB   = 5;
   localparam int unsigned REP_MSB   = 7;

   // uo_out fields
   localparam int unsigned DOUT_BIT  = 0;
   localparam int unsigned VALID_BIT = 1;
   localparam int unsigned BUSY_BIT  = 2;
   localparam int unsigned DONE_BIT  = 3;
   localparam int unsigned SOF_BIT   = 4;
   localparam int unsigned REPS_LSB  = 5;
   localparam int unsigned REPS_MSB  = 7;

   // MSB-first frames are left-aligned so the first bit always sits in [7];
   // LSB-first frames keep the first bit in [0].
   function automatic logic [7:0] align_pattern(input logic [7:0] pat,
                                                input logic [2:0] lenm1,
                                                input logic       msb_first);
      return msb_first ? (pat << (3'd7 - lenm1)) : pat;
   endfunction

   // Bit currently presented by an aligned shift register.
   function automatic logic head_bit(input logic [7:0] sr, input logic msb_first);
      return msb_first ? sr[7] : sr[0];
   endfunction

endpackage

// File: rtl/nh_start_sync.sv
// Two-flop synchronizer followed by a rising-edge detector; a level held
// high produces a single one-cycle pulse.
module nh_start_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic sync1;
   logic sync2;
   logic sync2_d;

   // Synchronizer chain plus delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync2_d <= 1'b0;
      end else begin
         sync1   <= din;
         sync2   <= sync1;
         sync2_d <= sync2;
      end
   end

   assign pulse = sync2 & ~sync2_d;

endmodule

// File: rtl/tt_um_nasser_hadi_pattern_tx.sv
// Serial pattern transmitter: captures a 1-8 bit pattern on a start edge and
// shifts it out, optionally repeating with zero-filled gaps between frames.
module tt_um_nasser_hadi_pattern_tx #(
   parameter int unsigned BIT_CYCLES = 1,
   parameter int unsigned GAP_BITS   = 2
) (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   import nasser_hadi_pkg::*;

   localparam logic [7:0] PRE_LAST = 8'(BIT_CYCLES - 1);
   localparam bit         HAS_GAP  = (GAP_BITS > 0);
   localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP_BITS - 1) : 4'd0;

   state_t     state;
   logic       start_pulse;
   logic [7:0] pat_q;
   logic [2:0] lenm1_q;
   logic       order_q;
   logic [7:0] shreg;
   logic [2:0] bitcnt;
   logic [2:0] reps;
   logic [7:0] pre;
   logic [3:0] gapcnt;
   logic       dout;
   logic       valid;
   logic       busy;
   logic       done;
   logic       sof;
   logic       bit_end;
   logic [7:0] reload_val;
   logic [7:0] shifted;
   logic       unused_ena;

   assign unused_ena = ena;

   nh_start_sync u_start_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (uio_in[START_BIT]),
      .pulse (start_pulse)
   );

   // Bit-period boundary and next shift-register contents.
   always_comb begin
      bit_end    = (pre == PRE_LAST);
      reload_val = align_pattern(pat_q, lenm1_q, order_q);
      shifted    = order_q ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};
   end

   // Transmit FSM with prescaler, bit/gap/repeat counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pat_q   <= '0;
         lenm1_q <= '0;
         order_q <= 1'b0;
         shreg   <= '0;
         bitcnt  <= '0;
         reps    <= '0;
         pre     <= '0;
         gapcnt  <= '0;
         dout    <= 1'b0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sof     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               pre   <= '0;
               dout  <= 1'b0;
               valid <= 1'b0;
               busy  <= 1'b0;
               sof   <= 1'b0;
               reps  <= '0;
               if (start_pulse) begin
                  pat_q   <= ui_in;
                  lenm1_q <= uio_in[LEN_MSB:LEN_LSB];
                  order_q <= uio_in[ORDER_BIT];
                  shreg   <= align_pattern(ui_in, uio_in[LEN_MSB:LEN_LSB], uio_in[ORDER_BIT]);
                  dout    <= head_bit(align_pattern(ui_in, uio_in[LEN_MSB:LEN_LSB],
                                                    uio_in[ORDER_BIT]), uio_in[ORDER_BIT]);
                  bitcnt  <= uio_in[LEN_MSB:LEN_LSB];
                  reps    <= uio_in[REP_MSB:REP_LSB];
                  valid   <= 1'b1;
                  busy    <= 1'b1;
                  sof     <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (!bit_end) begin
                  pre <= pre + 8'd1;
               end else begin
                  pre <= '0;
                  if (bitcnt != 3'd0) begin
                     shreg  <= shifted;
                     dout   <= head_bit(shifted, order_q);
                     bitcnt <= bitcnt - 3'd1;
                     sof    <= 1'b0;
                  end else if (reps != 3'd0 && HAS_GAP) begin
                     gapcnt <= GAP_LAST;
                     dout   <= 1'b0;
                     valid  <= 1'b0;
                     sof    <= 1'b0;
                     state  <= GAP;
                  end else if (reps != 3'd0) begin
                     shreg  <= reload_val;
                     dout   <= head_bit(reload_val, order_q);
                     bitcnt <= lenm1_q;
                     reps   <= reps - 3'd1;
                     sof    <= 1'b1;
                  end else begin
                     dout  <= 1'b0;
                     valid <= 1'b0;
                     sof   <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            GAP: begin
               if (!bit_end) begin
                  pre <= pre + 8'd1;
               end else begin
                  pre <= '0;
                  if (gapcnt != 4'd0) begin
                     gapcnt <= gapcnt - 4'd1;
                  end else begin
                     shreg  <= reload_val;
                     dout   <= head_bit(reload_val, order_q);
                     bitcnt <= lenm1_q;
                     reps   <= reps - 3'd1;
                     valid  <= 1'b1;
                     sof    <= 1'b1;
                     state  <= SHIFT;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Pack registered status into the output byte.
   always_comb begin
      uo_out                    = '0;
      uo_out[DOUT_BIT]          = dout;
      uo_out[VALID_BIT]         = valid;
      uo_out[BUSY_BIT]          = busy;
      uo_out[DONE_BIT]          = done;
      uo_out[SOF_BIT]           = sof;
      uo_out[REPS_MSB:REPS_LSB] = reps;
   end

   assign uio_out = '0;
   assign uio_oe  = '0;

endmodule
